// File: rtl/uart_cmd_scheduler_if.sv
// Request and UART-transmit bundle for uart_cmd_scheduler.
// The scheduler is the slave and the surrounding logic is the master.
interface uart_cmd_scheduler_if;
  logic       kb_valid;
  logic [7:0] kb_ascii;
  logic       btn_buy;
  logic       btn_sell;
  logic       btn_close;
  logic       at_buy;
  logic       at_sell;
  logic       at_close;
  logic       pair;
  logic       timer_en;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  modport master (
    output kb_valid, kb_ascii, btn_buy, btn_sell, btn_close,
    output at_buy, at_sell, at_close, pair, timer_en, tx_done,
    input  tx_data, tx_start, busy, timeout_err, drop_cnt
  );

  modport slave (
    input  kb_valid, kb_ascii, btn_buy, btn_sell, btn_close,
    input  at_buy, at_sell, at_close, pair, timer_en, tx_done,
    output tx_data, tx_start, busy, timeout_err, drop_cnt
  );
endinterface

// File: rtl/uart_cmd_scheduler.sv
// Arbitrates keyboard, manual, auto-trade and timer requests onto the
// shared UART transmitter as two-byte frames (opcode, argument).
module uart_cmd_scheduler #(
  parameter int unsigned TIMER_PERIOD = 1_000_000_000,
  parameter int unsigned HB_AT        = 10_000_000,
  parameter int unsigned REFRESH_AT   = 500_000_000,
  parameter int unsigned TX_TIMEOUT   = 2_000_000
) (
  input logic clk,
  input logic rst,
  uart_cmd_scheduler_if.slave bus
);

  localparam int unsigned TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
  localparam int unsigned WW = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, B0, W0, B1, W1} state_e;

  state_e            state_q, state_d;
  logic [15:0]       frame_q, frame_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              to_q, to_d;
  logic [7:0]        drop_q, drop_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [4:0]        v_q, v_d;
  logic [4:0][15:0]  fr_q, fr_d;

  logic [4:0]        req, cl, clr, win, drop;
  logic [4:0][15:0]  nf;
  logic [7:0]        arg;
  logic [2:0]        dsum;
  logic [8:0]        dtot;

  always_comb begin
    tmr_d = '0;
    if (bus.timer_en) begin
      tmr_d = (tmr_q == TW'(TIMER_PERIOD - 1)) ? '0 : tmr_q + TW'(1);
    end
  end

  // S1/S2 encode close > sell > buy when pulses coincide
  always_comb begin
    arg    = 8'h01 + {7'd0, bus.pair};
    req    = '0;
    cl     = '0;
    nf     = '0;
    req[0] = bus.kb_valid;
    nf[0]  = {8'h01, bus.kb_ascii};
    req[1] = bus.btn_buy | bus.btn_sell | bus.btn_close;
    cl[1]  = bus.btn_close;
    nf[1]  = {bus.btn_close ? 8'h04 : bus.btn_sell ? 8'h03 : 8'h02, arg};
    req[2] = bus.at_buy | bus.at_sell | bus.at_close;
    cl[2]  = bus.at_close;
    nf[2]  = {bus.at_close ? 8'h04 : bus.at_sell ? 8'h03 : 8'h02, arg};
    req[3] = bus.timer_en && (tmr_d == TW'(HB_AT));
    nf[3]  = {8'h06, arg};
    req[4] = bus.timer_en && (tmr_d == TW'(REFRESH_AT));
    nf[4]  = {8'h05, arg};
  end

  // Lowest index pending wins
  assign win = v_q & (~v_q + 5'd1);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    wcnt_d  = wcnt_q;
    to_d    = to_q;
    clr     = '0;
    unique case (state_q)
      IDLE: if (|v_q) state_d = LOAD;
      LOAD: begin
        clr     = win;
        state_d = B0;
        for (int i = 0; i < 5; i++) begin
          if (win[i]) frame_d = fr_q[i];
        end
      end
      B0: begin
        wcnt_d  = '0;
        state_d = W0;
      end
      W0: begin
        if (bus.tx_done) begin
          state_d = B1;
        end else if (wcnt_q == WW'(TX_TIMEOUT - 1)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      B1: begin
        wcnt_d  = '0;
        state_d = W1;
      end
      W1: begin
        if (bus.tx_done) begin
          state_d = IDLE;
        end else if (wcnt_q == WW'(TX_TIMEOUT - 1)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A slot cleared by LOAD this cycle counts as empty for capture
  always_comb begin
    v_d  = '0;
    fr_d = fr_q;
    drop = '0;
    dsum = '0;
    for (int i = 0; i < 5; i++) begin
      v_d[i] = v_q[i] & ~clr[i];
      if (req[i]) begin
        if (!v_d[i] || (cl[i] && fr_q[i][15:8] inside {8'h02, 8'h03})) begin
          v_d[i]  = 1'b1;
          fr_d[i] = nf[i];
        end else begin
          drop[i] = 1'b1;
        end
      end
      dsum = dsum + {2'd0, drop[i]};
    end
    dtot   = {1'b0, drop_q} + {6'd0, dsum};
    drop_d = dtot[8] ? 8'hFF : dtot[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      drop_q  <= '0;
      tmr_q   <= '0;
      v_q     <= '0;
      fr_q    <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
      tmr_q   <= tmr_d;
      v_q     <= v_d;
      fr_q    <= fr_d;
    end
  end

  assign bus.tx_start    = (state_q == B0) || (state_q == B1);
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = to_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.tx_data     = (state_q == B0 || state_q == W0) ? frame_q[15:8] :
                           (state_q == B1 || state_q == W1) ? frame_q[7:0]  :
                           8'h00;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench for uart_cmd_scheduler: one instance with a long
// tx timeout for frame traffic, one with a short timeout.
module tb_uart_cmd_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  uart_cmd_scheduler_if a ();
  uart_cmd_scheduler_if b ();

  uart_cmd_scheduler #(
    .TIMER_PERIOD(100), .HB_AT(10), .REFRESH_AT(50), .TX_TIMEOUT(1000)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(a)
  );

  uart_cmd_scheduler #(
    .TIMER_PERIOD(100), .HB_AT(10), .REFRESH_AT(50), .TX_TIMEOUT(20)
  ) u_to (
    .clk(clk), .rst(rst), .bus(b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int lim, output int cnt);
    cnt = 0;
    while (!a.tx_start && cnt < lim) begin
      tick();
      cnt++;
    end
    chk({tag, "_start"}, a.tx_start, 1);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input int dly, input string tag);
    chk({tag, "_b0"}, a.tx_data, b0);
    repeat (dly - 1) tick();
    chk({tag, "_hold0"}, {a.tx_start, a.tx_data}, {1'b0, b0});
    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    chk({tag, "_st1"}, a.tx_start, 1);
    chk({tag, "_b1"}, a.tx_data, b1);
    repeat (dly - 1) tick();
    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    chk({tag, "_idle"}, a.busy, 0);
  endtask

  initial begin
    a.kb_valid = 0; a.kb_ascii = 0; a.btn_buy = 0; a.btn_sell = 0;
    a.btn_close = 0; a.at_buy = 0; a.at_sell = 0; a.at_close = 0;
    a.pair = 0; a.timer_en = 0; a.tx_done = 0;
    b.kb_valid = 0; b.kb_ascii = 0; b.btn_buy = 0; b.btn_sell = 0;
    b.btn_close = 0; b.at_buy = 0; b.at_sell = 0; b.at_close = 0;
    b.pair = 0; b.timer_en = 0; b.tx_done = 0;

    repeat (3) tick();
    chk("rst_data", a.tx_data, 0);
    chk("rst_start", a.tx_start, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_to", a.timeout_err, 0);
    chk("rst_drop", a.drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Keyboard, plus a same-slot request landing during LOAD
    a.kb_valid = 1; a.kb_ascii = 8'h41;
    tick();
    a.kb_valid = 0;
    chk("kb_idle", a.busy, 0);
    tick();
    chk("kb_load", {a.busy, a.tx_start}, 2'b10);
    a.kb_valid = 1; a.kb_ascii = 8'h42;
    tick();
    a.kb_valid = 0;
    chk("kb_b0_start", a.tx_start, 1);
    run_frame(8'h01, 8'h41, 100, "kb1");
    wait_start("kb2", 5, n);
    chk("kb2_lat", n, 2);
    run_frame(8'h01, 8'h42, 3, "kb2");
    chk("kb_drop", a.drop_cnt, 0);

    // Manual beats auto; pair sampled at capture
    a.btn_buy = 1; a.at_sell = 1; a.pair = 1;
    tick();
    a.btn_buy = 0; a.at_sell = 0; a.pair = 0;
    wait_start("man", 5, n);
    chk("man_lat", n, 2);
    run_frame(8'h02, 8'h02, 5, "man");
    wait_start("auto", 5, n);
    chk("auto_lat", n, 2);
    run_frame(8'h03, 8'h02, 5, "auto");
    chk("pri_drop", a.drop_cnt, 0);

    // Drop on full slot, close overwrites pending buy
    a.btn_buy = 1;
    tick();
    a.btn_buy = 0;
    wait_start("stall", 5, n);
    a.btn_buy = 1;
    tick();
    a.btn_buy = 0;
    tick();
    a.btn_buy = 1;
    tick();
    a.btn_buy = 0;
    chk("drop_one", a.drop_cnt, 1);
    a.btn_close = 1;
    tick();
    a.btn_close = 0;
    chk("close_nodrop", a.drop_cnt, 1);
    run_frame(8'h02, 8'h01, 3, "stall");
    wait_start("close", 5, n);
    chk("close_lat", n, 2);
    run_frame(8'h04, 8'h01, 3, "close");
    chk("close_drop", a.drop_cnt, 1);

    // Timer heartbeat / refresh cadence
    a.timer_en = 1;
    wait_start("hb1", 20, n);
    chk("hb1_lat", n, 12);
    run_frame(8'h06, 8'h01, 5, "hb1");
    wait_start("ref", 40, n);
    chk("ref_lat", n, 30);
    run_frame(8'h05, 8'h01, 5, "ref");
    wait_start("hb2", 60, n);
    chk("hb2_lat", n, 50);
    run_frame(8'h06, 8'h01, 5, "hb2");
    a.timer_en = 0;

    // Timeout: W0 waits 20 cycles, then the next pending is served
    b.kb_valid = 1; b.kb_ascii = 8'h55; b.btn_sell = 1;
    tick();
    b.kb_valid = 0; b.btn_sell = 0;
    n = 0;
    while (!b.tx_start && n < 5) begin
      tick();
      n++;
    end
    chk("to_start", {b.tx_start, b.tx_data}, {1'b1, 8'h01});
    chk("to_err_pre", b.timeout_err, 0);
    n = 0;
    while (b.busy && n < 40) begin
      tick();
      n++;
    end
    chk("to_len", n, 21);
    chk("to_err", b.timeout_err, 1);
    tick();
    tick();
    chk("to_next", {b.tx_start, b.tx_data}, {1'b1, 8'h03});

    // Reset during W1 clears outputs and the pending auto slot
    a.btn_sell = 1; a.at_buy = 1; a.pair = 1;
    tick();
    a.btn_sell = 0; a.at_buy = 0; a.pair = 0;
    wait_start("rw", 5, n);
    chk("rw_b0", a.tx_data, 8'h03);
    repeat (2) tick();
    a.tx_done = 1;
    tick();
    a.tx_done = 0;
    chk("rw_b1", a.tx_data, 8'h02);
    tick();
    chk("rw_w1", {a.busy, a.tx_start}, 2'b10);
    rst = 1'b1;
    #1;
    chk("rw_data", a.tx_data, 0);
    chk("rw_start", a.tx_start, 0);
    chk("rw_busy", a.busy, 0);
    chk("rw_drop", a.drop_cnt, 0);
    chk("rw_to", b.timeout_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (!a.busy && n < 10) begin
      tick();
      n++;
    end
    chk("rw_slot_clear", n, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
